// File: rtl/cpu_pkg.sv
// Shared definitions for the core-side memory path: bus widths and the
// memory controller state encoding.
package cpu_pkg;

    localparam int CORE_ADDR_W = 24;
    localparam int CORE_DATA_W = 16;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_SETUP  = 3'd1,
        MC_ACCESS = 3'd2,
        MC_DONE   = 3'd3,
        MC_ERR    = 3'd4
    } mc_state_e;

    // Chip enable is held low only while the SRAM cycle is open.
    function automatic logic mc_strobing(input mc_state_e s);
        return (s == MC_SETUP) || (s == MC_ACCESS);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the SRAM access phase; it stops
// at zero and flags it.
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_controller.sv
// Core-to-async-SRAM bridge: single-word read/write with programmable wait
// states, registered glitch-free strobes and out-of-range address flagging.
module mem_controller
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [CORE_ADDR_W-1:0] core_addr,
    input  logic [CORE_DATA_W-1:0] core_wdata,
    output logic [CORE_DATA_W-1:0] core_rdata,
    output logic                   core_ready,
    output logic                   core_err,
    output logic                   core_busy,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [CORE_DATA_W-1:0] sram_wdata,
    input  logic [CORE_DATA_W-1:0] sram_rdata,
    output logic                   sram_data_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    // Any bit set above the implemented SRAM width marks an illegal address.
    localparam logic [CORE_ADDR_W-1:0] HI_MASK =
        ~((CORE_ADDR_W'(1) << ADDR_W) - CORE_ADDR_W'(1));

    mc_state_e r_state, w_next_state;

    logic                   r_we;
    logic                   r_ce_n, r_oe_n, r_we_n, r_data_oe;
    logic                   r_ready, r_err, r_busy;
    logic [CORE_DATA_W-1:0] r_rdata, r_wdata;
    logic [ADDR_W-1:0]      r_sram_addr;

    logic w_accept, w_oor, w_we, w_cnt_zero, w_next_strobe, w_next_data;

    assign w_accept = (r_state == MC_IDLE) && core_req;
    assign w_oor    = |(core_addr & HI_MASK);
    // Outputs are registered from the next state, so in IDLE the direction
    // must come straight from the request being accepted.
    assign w_we     = (r_state == MC_IDLE) ? core_we : r_we;

    mem_wait_counter u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == MC_SETUP),
        .i_load_val (4'(WAIT_STATES)),
        .i_dec      (r_state == MC_ACCESS),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state is given a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            MC_IDLE:   if (core_req) w_next_state = w_oor ? MC_ERR : MC_SETUP;
            MC_SETUP:  w_next_state = MC_ACCESS;
            MC_ACCESS: if (w_cnt_zero) w_next_state = MC_DONE;
            MC_DONE:   w_next_state = MC_IDLE;
            MC_ERR:    w_next_state = MC_IDLE;
            default:   w_next_state = MC_IDLE;
        endcase
    end

    assign w_next_strobe = mc_strobing(w_next_state);
    assign w_next_data   = w_next_strobe || (w_next_state == MC_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_sram_addr <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we <= core_we;
            end
            if (w_accept && !w_oor) begin
                r_sram_addr <= core_addr[ADDR_W-1:0];
                r_wdata     <= core_wdata;
            end
            if ((r_state == MC_ACCESS) && w_cnt_zero && !r_we) begin
                r_rdata <= sram_rdata;
            end
            r_ce_n    <= !w_next_strobe;
            r_oe_n    <= !(w_next_strobe && !w_we);
            // Write strobe opens one cycle after the address settles in SETUP.
            r_we_n    <= !((w_next_state == MC_ACCESS) && w_we);
            r_data_oe <= w_next_data && w_we;
            r_ready   <= (w_next_state == MC_DONE) || (w_next_state == MC_ERR);
            r_err     <= (w_next_state == MC_ERR);
            r_busy    <= (w_next_state != MC_IDLE);
        end
    end

    assign core_rdata   = r_rdata;
    assign core_ready   = r_ready;
    assign core_err     = r_err;
    assign core_busy    = r_busy;
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_wdata;
    assign sram_data_oe = r_data_oe;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: directed cases plus randomized
// transactions against a word-level memory scoreboard.
module tb_mem_controller;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, WAIT_STATES = 2
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [23:0] core_addr = '0;
    logic [15:0] core_wdata = '0;
    logic [15:0] core_rdata, sram_wdata, sram_rdata;
    logic        core_ready, core_err, core_busy;
    logic [15:0] sram_addr;
    logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;

    mem_controller #(.ADDR_W(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .core_err(core_err), .core_busy(core_busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    // Second instance, WAIT_STATES = 0
    logic        z_req = 1'b0, z_we = 1'b0;
    logic [23:0] z_addr = '0;
    logic [15:0] z_wdata = '0;
    logic [15:0] z_rdata, z_sram_wdata, z_sram_rdata;
    logic        z_ready, z_err, z_busy;
    logic [15:0] z_sram_addr;
    logic        z_data_oe, z_ce_n, z_oe_n, z_we_n;

    mem_controller #(.ADDR_W(16), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst_n(rst_n),
        .core_req(z_req), .core_we(z_we), .core_addr(z_addr),
        .core_wdata(z_wdata), .core_rdata(z_rdata), .core_ready(z_ready),
        .core_err(z_err), .core_busy(z_busy),
        .sram_addr(z_sram_addr), .sram_wdata(z_sram_wdata), .sram_rdata(z_sram_rdata),
        .sram_data_oe(z_data_oe), .sram_ce_n(z_ce_n),
        .sram_oe_n(z_oe_n), .sram_we_n(z_we_n)
    );

    // External SRAM device models
    logic [15:0] sram_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) sram_mem[i] = 16'(i) ^ 16'h5A5A;
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_data_oe) sram_mem[sram_addr] <= sram_wdata;

    assign z_sram_rdata = (!z_ce_n && !z_oe_n) ? (z_sram_addr ^ 16'hA5C3) : 16'hDEAD;

    // Scoreboard: expected memory contents and last completed read
    logic [15:0] ref_mem [int];
    logic [15:0] last_rdata = 16'h0000;

    function automatic logic [15:0] exp_word(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : (16'(a) ^ 16'h5A5A);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction starting in an IDLE cycle (cycle 0). Returns at the
    // negedge of the ready cycle; hold keeps core_req high for a follow-on.
    task automatic run_txn(input logic we, input logic [23:0] addr,
                           input logic [15:0] wdata, input bit hold,
                           output int ready_cyc);
        bit          exp_err;
        int          exp_lat, lat;
        int          oe_cnt, we_cnt, doe_cnt, ce_cnt, overlap, busy_cnt;
        logic [15:0] exp_rd, a1, wd1, rd_at;
        logic        err_at;
        exp_err = (addr >= 24'h010000);
        exp_lat = exp_err ? 1 : WS + 3;
        exp_rd  = (!exp_err && !we) ? exp_word(int'(addr)) : last_rdata;
        lat = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; ce_cnt = 0;
        overlap = 0; busy_cnt = 0; ready_cyc = -1;
        a1 = '0; wd1 = '0; rd_at = '0; err_at = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(core_ready), 32'd0);
        check("idle_busy", 32'(core_busy), 32'd0);
        check("idle_data_oe", 32'(sram_data_oe), 32'd0);
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin a1 = sram_addr; wd1 = sram_wdata; end
            if (!sram_ce_n) ce_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (sram_data_oe) doe_cnt++;
            if (!sram_oe_n && !sram_we_n) overlap++;
            if (core_busy) busy_cnt++;
            if (core_ready) begin
                lat = k; ready_cyc = cyc; rd_at = core_rdata; err_at = core_err;
                if (!hold) core_req = 1'b0;
            end else begin
                // Inputs in flight must not disturb the transaction.
                core_we = 1'($urandom); core_addr = 24'($urandom); core_wdata = 16'($urandom);
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(err_at), 32'(exp_err));
        check("rdata", 32'(rd_at), 32'(exp_rd));
        check("ce_low_cycles", 32'(ce_cnt), exp_err ? 32'd0 : 32'(WS + 2));
        check("oe_low_cycles", 32'(oe_cnt), (!exp_err && !we) ? 32'(WS + 2) : 32'd0);
        check("we_low_cycles", 32'(we_cnt), (!exp_err && we) ? 32'(WS + 1) : 32'd0);
        check("data_oe_cycles", 32'(doe_cnt), (!exp_err && we) ? 32'(WS + 3) : 32'd0);
        check("oe_we_overlap", 32'(overlap), 32'd0);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        if (!exp_err) check("sram_addr", 32'(a1), 32'(addr[15:0]));
        if (!exp_err && we) check("sram_wdata", 32'(wd1), 32'(wdata));
        if (!exp_err && we) ref_mem[int'(addr)] = wdata;
        last_rdata = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, c2, lat, oe_cnt, ce_cnt;
        logic [15:0] rd;
        logic [23:0] pool [8];
        logic [23:0] a;
        pool = '{24'h000000, 24'h000001, 24'h000010, 24'h007FFF,
                 24'h008000, 24'h00FFFE, 24'h00FFFF, 24'h001234};

        // Reset values while reset is held
        #12;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_data_oe", 32'(sram_data_oe), 32'd0);
        check("rst_rdata", 32'(core_rdata), 32'd0);
        check("rst_ready", 32'(core_ready), 32'd0);
        check("rst_err", 32'(core_err), 32'd0);
        check("rst_busy", 32'(core_busy), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Read with SRAM returning 0xBEEF
        sram_mem[16'h0010] = 16'hBEEF;
        ref_mem[32'h10] = 16'hBEEF;
        run_txn(1'b0, 24'h000010, 16'h0000, 1'b0, c0);

        // Write at the top legal address, then read it back
        run_txn(1'b1, 24'h00FFFF, 16'h1234, 1'b0, c0);
        run_txn(1'b0, 24'h00FFFF, 16'h0000, 1'b0, c0);

        // First illegal address
        run_txn(1'b0, 24'h010000, 16'h0000, 1'b0, c0);

        // Back-to-back reads with core_req held high
        run_txn(1'b0, 24'h000100, 16'h0000, 1'b1, c0);
        run_txn(1'b0, 24'h000200, 16'h0000, 1'b1, c1);
        run_txn(1'b0, 24'h000300, 16'h0000, 1'b0, c2);
        check("b2b_gap_1", 32'(c1 - c0), 32'(WS + 4));
        check("b2b_gap_2", 32'(c2 - c1), 32'(WS + 4));

        // Reset asserted during the ACCESS phase of a write
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 24'h00ABCD; core_wdata = 16'h5555;
        repeat (2) @(negedge clk);
        check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_we_n", 32'(sram_we_n), 32'd1);
        check("async_ce_n", 32'(sram_ce_n), 32'd1);
        check("async_data_oe", 32'(sram_data_oe), 32'd0);
        check("async_busy", 32'(core_busy), 32'd0);
        check("async_rdata", 32'(core_rdata), 32'd0);
        core_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        run_txn(1'b0, 24'h000010, 16'h0000, 1'b0, c0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = {8'($urandom_range(1, 255)), 16'($urandom)};
            else
                a = pool[$urandom_range(0, 7)];
            run_txn(1'($urandom), a, 16'($urandom), (i < 39) ? 1'($urandom) : 1'b0, c0);
        end

        // Zero wait states: single read
        @(negedge clk);
        z_req = 1'b1; z_we = 1'b0; z_addr = 24'h000042;
        lat = 0; oe_cnt = 0; ce_cnt = 0; rd = '0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (!z_oe_n) oe_cnt++;
            if (!z_ce_n) ce_cnt++;
            if (z_ready) begin lat = k; rd = z_rdata; z_req = 1'b0; end
        end
        check("ws0_latency", 32'(lat), 32'd3);
        check("ws0_oe_low_cycles", 32'(oe_cnt), 32'd2);
        check("ws0_ce_low_cycles", 32'(ce_cnt), 32'd2);
        check("ws0_rdata", 32'(rd), 32'(16'h0042 ^ 16'hA5C3));
        check("ws0_err", 32'(z_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
